// File: rtl/sort_frame_buf_pkg.sv
// Shared definitions for the sort frame buffer and the selection-sort stage.
// Default sample geometry, bank state encoding, pad value and slot indexing.
package sort_pkg;

    localparam int SORT_N     = 8;
    localparam int SORT_K     = 10;
    localparam int SORT_MAX_N = 64;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_e;

    // Callers narrow this to their own sample width with a size cast.
    function automatic logic [SORT_MAX_N-1:0] PAD_VALUE();
        return '1;
    endfunction

    function automatic int slot_lo(input int slot, input int width);
        return slot * width;
    endfunction

endpackage

// File: rtl/sort_frame_buf_if.sv
// Sample stream and frame handshake between feeder, buffer and sorter.
// in_last exists only when SORT_FRAME_PAD_EN is defined.
interface sort_frame_buf_if #(
    parameter int N = 8,
    parameter int K = 10
) ();
    localparam int CW = $clog2(K + 1);

    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
`ifdef SORT_FRAME_PAD_EN
    logic          in_last;
`endif
    logic          frame_valid;
    logic          frame_ready;
    logic [N*K-1:0] frame_data;
    logic [CW-1:0] frame_len;

    modport slave (
        input  in_valid,
        input  in_data,
`ifdef SORT_FRAME_PAD_EN
        input  in_last,
`endif
        input  frame_ready,
        output in_ready,
        output frame_valid,
        output frame_data,
        output frame_len
    );

    modport master (
        output in_valid,
        output in_data,
`ifdef SORT_FRAME_PAD_EN
        output in_last,
`endif
        output frame_ready,
        input  in_ready,
        input  frame_valid,
        input  frame_data,
        input  frame_len
    );

endinterface

// File: rtl/sort_frame_buf_bank.sv
// One K x N sample bank: slot write port, tail padding on close, bank state
// and stored frame length. state_nx exposes the next state to the pointer logic.
module sort_frame_bank
    import sort_pkg::*;
#(
    parameter int N = SORT_N,
    parameter int K = SORT_K,
    localparam int CW = $clog2(K + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clear,
    input  logic           wr_en,
    input  logic           wr_close,
    input  logic [CW-1:0]  wr_idx,
    input  logic [N-1:0]   wr_data,
    input  logic           rd_release,
    output bank_state_e    state_q,
    output bank_state_e    state_nx,
    output logic [N*K-1:0] data,
    output logic [CW-1:0]  len_q
);

    localparam logic [N-1:0] PAD = N'(PAD_VALUE());

    bank_state_e   state_d;
    logic [N-1:0]  slots_q [K];
    logic [N-1:0]  slots_d [K];
    logic [CW-1:0] len_d;

    // Release and write never target the same bank in one cycle: a FULL bank
    // is never the write target while its in_ready is low.
    always_comb begin
        state_d = state_q;
        slots_d = slots_q;
        len_d   = len_q;
        if (clear) begin
            state_d = EMPTY;
            len_d   = '0;
            for (int j = 0; j < K; j++) begin
                slots_d[j] = '0;
            end
        end else begin
            if (rd_release) begin
                state_d = EMPTY;
            end
            if (wr_en) begin
                for (int j = 0; j < K; j++) begin
                    if (CW'(j) == wr_idx) begin
                        slots_d[j] = wr_data;
                    end else if (wr_close && (CW'(j) > wr_idx)) begin
                        slots_d[j] = PAD;
                    end
                end
                if (wr_close) begin
                    state_d = FULL;
                    len_d   = wr_idx + CW'(1);
                end else begin
                    state_d = FILLING;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            len_q   <= '0;
            for (int j = 0; j < K; j++) begin
                slots_q[j] <= '0;
            end
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            slots_q <= slots_d;
        end
    end

    always_comb begin
        data = '0;
        for (int j = 0; j < K; j++) begin
            data[slot_lo(j, N) +: N] = slots_q[j];
        end
    end

    assign state_nx = state_d;

endmodule

// File: rtl/sort_frame_buf.sv
// Ping-pong frame buffer feeding the selection sorter: two banks, write/read
// pointers and handshakes. Optional early close via in_last: SORT_FRAME_PAD_EN.
module sort_frame_buf
    import sort_pkg::*;
#(
    parameter int N = SORT_N,
    parameter int K = SORT_K,
    localparam int CW = $clog2(K + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    sort_frame_buf_if.slave    bus,
    output logic [15:0]        frames_out
);

    logic          wr_sel_q, wr_sel_d;
    logic          rd_sel_q, rd_sel_d;
    logic [CW-1:0] fill_cnt_q, fill_cnt_d;
    logic [15:0]   frames_out_q, frames_out_d;
    logic          in_ready_q, in_ready_d;

    bank_state_e    bank_state_q  [2];
    bank_state_e    bank_state_nx [2];
    logic [N*K-1:0] bank_data     [2];
    logic [CW-1:0]  bank_len      [2];

    logic       last_in;
    logic       xfer;
    logic       close;
    logic       fvalid;
    logic       accept;
    logic [1:0] wr_en;
    logic [1:0] rel;
    logic [1:0] full_nx;

`ifdef SORT_FRAME_PAD_EN
    assign last_in = bus.in_last;
`else
    assign last_in = 1'b0;
`endif

    // flush masks both handshakes so a same-cycle transfer or accept is dropped.
    always_comb begin
        xfer   = bus.in_valid && in_ready_q && !flush;
        close  = xfer && ((fill_cnt_q == CW'(K - 1)) || last_in);
        fvalid = (bank_state_q[rd_sel_q] == FULL);
        accept = fvalid && bus.frame_ready && !flush;
        for (int b = 0; b < 2; b++) begin
            wr_en[b] = xfer && (wr_sel_q == 1'(b));
            rel[b]   = accept && (rd_sel_q == 1'(b));
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        sort_frame_bank #(
            .N (N),
            .K (K)
        ) u_bank (
            .clk        (clk),
            .rst_n      (rst_n),
            .clear      (flush),
            .wr_en      (wr_en[g]),
            .wr_close   (close),
            .wr_idx     (fill_cnt_q),
            .wr_data    (bus.in_data),
            .rd_release (rel[g]),
            .state_q    (bank_state_q[g]),
            .state_nx   (bank_state_nx[g]),
            .data       (bank_data[g]),
            .len_q      (bank_len[g])
        );
    end

    // Pointers look at next-cycle bank states, so a bank freed in the same
    // cycle as the other completes becomes the write target without a bubble.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            full_nx[b] = (bank_state_nx[b] == FULL);
        end
        fill_cnt_d   = fill_cnt_q;
        rd_sel_d     = rd_sel_q;
        wr_sel_d     = wr_sel_q;
        frames_out_d = frames_out_q;
        if (flush) begin
            fill_cnt_d = '0;
            rd_sel_d   = 1'b0;
            wr_sel_d   = 1'b0;
        end else begin
            if (close) begin
                fill_cnt_d = '0;
            end else if (xfer) begin
                fill_cnt_d = fill_cnt_q + CW'(1);
            end
            if (accept) begin
                rd_sel_d     = ~rd_sel_q;
                frames_out_d = frames_out_q + 16'd1;
            end
            if (full_nx[wr_sel_q] && !full_nx[~wr_sel_q]) begin
                wr_sel_d = ~wr_sel_q;
            end
        end
        in_ready_d = !full_nx[wr_sel_d];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_sel_q     <= 1'b0;
            rd_sel_q     <= 1'b0;
            fill_cnt_q   <= '0;
            frames_out_q <= '0;
            in_ready_q   <= 1'b0;
        end else begin
            wr_sel_q     <= wr_sel_d;
            rd_sel_q     <= rd_sel_d;
            fill_cnt_q   <= fill_cnt_d;
            frames_out_q <= frames_out_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.frame_valid = fvalid;
    assign bus.frame_data  = bank_data[rd_sel_q];
    assign bus.frame_len   = bank_len[rd_sel_q];
    assign frames_out      = frames_out_q;

endmodule

// File: doc/sort_frame_buf.md
Name: sort_frame_buf

Overview:
- Upstream feeder for the selection-sort stage.
- Collects K unsigned N-bit samples from a valid/ready stream into one of two ping-pong register banks.
- Presents each completed bank as a parallel frame to the sorter over a valid/ready frame handshake.
- Input keeps filling the second bank while the sorter holds the first.

Parameters:
N, 8, sample width in bits
K, 10, samples per frame (K >= 2)
CW, $clog2(K+1), width of fill counter and frame length

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of both banks and all state
in_valid  input  1  sample valid
in_ready  output  1  buffer can accept a sample this cycle
in_data  input  N  sample value
frame_valid  output  1  a full bank is presented on frame_data
frame_ready  input  1  sorter accepts the frame (sorter idle/start)
frame_data  output  N*K  slot j at bits [j*N +: N], slot 0 = first sample received
frame_len  output  CW  number of real samples in the frame (K unless padded)
frames_out  output  16  count of frames accepted, wraps at 0xFFFF

Behaviour:
- Reset (rst_n low, async): both banks EMPTY, wr_sel=0, rd_sel=0, fill count 0, frames_out=0, in_ready=0, frame_valid=0, frame_len=0, frame_data=0. in_ready rises the first cycle after reset release.
- Per-bank state: EMPTY -> FILLING -> FULL -> EMPTY.
- Input transfer: occurs on in_valid && in_ready. The sample is written to bank[wr_sel] slot fill_cnt; fill_cnt increments.
- Frame completion: the transfer with fill_cnt==K-1 marks bank[wr_sel] FULL and records frame_len=K.
  - Next cycle, wr_sel flips if the other bank is EMPTY.
  - Otherwise in_ready stays low until a bank frees.
- in_ready = (bank[wr_sel] not FULL). in_ready is registered, with no combinational path from in_valid.
- Output side:
  - frame_valid = bank[rd_sel] FULL.
  - frame_data and frame_len come from bank[rd_sel] and are stable while frame_valid && !frame_ready.
  - On frame_valid && frame_ready, bank[rd_sel] goes EMPTY, rd_sel flips, and frames_out increments.
- Ordering: frames leave in fill order. rd_sel only ever points at the oldest FULL bank.
- Latency: the frame is visible (frame_valid=1) the cycle after its K-th sample transfers.
- Simultaneous events:
  - A frame accept and a completion of the other bank in the same cycle are both honoured. The freed bank becomes the next write target immediately, so in_ready stays high with no bubble.
  - If both banks were FULL, the accept frees one and in_ready rises the next cycle.
- flush: same effect as reset except frames_out is kept.
  - It overrides a same-cycle transfer or accept; neither takes effect and frames_out does not increment.
- Reset asserted mid-frame discards partial data with no output.
- Sample values are stored unmodified as unsigned. No arithmetic is applied beyond the counters.

Optional Feature:
- Macro SORT_FRAME_PAD_EN.
- Defined:
  - Adds an input port in_last (1 bit). A transfer with in_last=1 closes the frame early.
  - The remaining slots are written as all-ones (max value, so they sort to the tail), and frame_len = samples received.
  - in_last on the K-th sample has no extra effect.
  - Padding completes in the same cycle, so frame_valid is still visible the next cycle.
- Not defined: the in_last port is absent, frames are always exactly K samples, and frame_len is constant K.

Decomposition:
- Package sort_pkg:
  - default N, K;
  - bank state enum {EMPTY, FILLING, FULL};
  - PAD_VALUE function returning all-ones of width N;
  - slot-index helper for the N*K packed bus (shared with the sorter).
- One sub-module, sort_frame_bank: a single K×N register bank with write port, pad fill, state, and stored length. Instantiated twice.
- The top holds the ping-pong pointers and handshakes.

Test Plan:
1. Reset, then stream 42,12,02,20,2a,29,22,52,01,00 with frame_ready=1 -> frame_valid=1 exactly one cycle after the 10th transfer; frame_data slot0=0x42, slot9=0x00; frame_len=10; frames_out=1.
2. frame_ready=0, stream 20 samples -> two frames FULL and in_ready=0 after sample 20. Raise frame_ready for one cycle -> frame 1 is accepted, frame 2 is presented next, in_ready=1 the next cycle.
3. Back-to-back: continuous in_valid with frame_ready pulsing at completions -> no in_ready bubble; 3 frames with frames_out=3, data in order.
4. flush asserted after 5 samples -> in_ready=1, frame_valid=0; the next 10 samples form a clean frame with no residue.
5. rst_n pulsed low while frame_valid=1 -> all outputs go to reset values asynchronously, and frames_out=0.
6. (SORT_FRAME_PAD_EN) 4 samples with in_last on the 4th -> frame_len=4, slots 4..9 = 0xFF, frame_valid the next cycle.
